// File: rtl/character_renderer.sv
// ============================================================================
// Module      : character_renderer
// Description : Erases the previous square character box and draws the new one,
//               emitting one VGA pixel write per clock.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module character_renderer #(
    parameter int          BOX_SIZE  = 4,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic       iClock,
    input  logic       iResetn,
    input  logic       iStart,
    input  logic [7:0] iX,
    input  logic [6:0] iY,
    input  logic [2:0] iColour,
    output logic [7:0] oX,
    output logic [6:0] oY,
    output logic [2:0] oColour,
    output logic       oPlot,
    output logic       oBusy,
    output logic       oDone
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ERASE = 2'd1;
    localparam logic [1:0] c_DRAW  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [2:0] c_LAST  = 3'(BOX_SIZE - 1);
    localparam logic [8:0] c_X_MAX = 9'd159;
    localparam logic [7:0] c_Y_MAX = 8'd119;

    logic [1:0] r_state;
    logic [1:0] w_next_state;

    logic [2:0] r_dx;
    logic [2:0] r_dy;
    logic [7:0] r_new_x;
    logic [6:0] r_new_y;
    logic [2:0] r_new_colour;
    logic [7:0] r_old_x;
    logic [6:0] r_old_y;
    logic       r_old_valid;

    logic       w_last;
    logic       w_active;
    logic [7:0] w_base_x;
    logic [6:0] w_base_y;
    logic [2:0] w_colour;
    logic [8:0] w_sum_x;
    logic [7:0] w_sum_y;
    logic       w_plot;
    logic       w_done;

    assign w_last = (r_dx == c_LAST) && (r_dy == c_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (iStart) begin
                    w_next_state = r_old_valid ? c_ERASE : c_DRAW;
                end
            end
            c_ERASE: begin
                if (w_last) begin
                    w_next_state = c_DRAW;
                end
            end
            c_DRAW: begin
                if (w_last) begin
                    w_next_state = c_DONE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: sums are one bit wider so off-screen pixels clip
    // instead of wrapping back onto the visible area.
    // ------------------------------------------------------------------
    always_comb begin
        w_active = (r_state == c_ERASE) || (r_state == c_DRAW);
        w_done   = (r_state == c_DONE);
        w_base_x = r_new_x;
        w_base_y = r_new_y;
        w_colour = r_new_colour;
        if (r_state == c_ERASE) begin
            w_base_x = r_old_x;
            w_base_y = r_old_y;
            w_colour = BG_COLOUR;
        end
        w_sum_x = {1'b0, w_base_x} + {6'b0, r_dx};
        w_sum_y = {1'b0, w_base_y} + {5'b0, r_dy};
        w_plot  = w_active && (w_sum_x <= c_X_MAX) && (w_sum_y <= c_Y_MAX);
    end

    // ------------------------------------------------------------------
    // Raster counters and position registers
    // ------------------------------------------------------------------
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            r_dx         <= 3'd0;
            r_dy         <= 3'd0;
            r_new_x      <= 8'd0;
            r_new_y      <= 7'd0;
            r_new_colour <= 3'd0;
            r_old_x      <= 8'd0;
            r_old_y      <= 7'd0;
            r_old_valid  <= 1'b0;
        end else begin
            if ((r_state == c_IDLE) && iStart) begin
                r_new_x      <= iX;
                r_new_y      <= iY;
                r_new_colour <= iColour;
                r_dx         <= 3'd0;
                r_dy         <= 3'd0;
            end else if (w_active) begin
                if (w_last) begin
                    r_dx <= 3'd0;
                    r_dy <= 3'd0;
                end else if (r_dx == c_LAST) begin
                    r_dx <= 3'd0;
                    r_dy <= r_dy + 3'd1;
                end else begin
                    r_dx <= r_dx + 3'd1;
                end
            end
            if ((r_state == c_DRAW) && w_last) begin
                r_old_x     <= r_new_x;
                r_old_y     <= r_new_y;
                r_old_valid <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered VGA outputs; coordinates hold while nothing is plotted
    // ------------------------------------------------------------------
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            oX      <= 8'd0;
            oY      <= 7'd0;
            oColour <= 3'd0;
            oPlot   <= 1'b0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
        end else begin
            oPlot <= w_plot;
            oBusy <= w_active;
            oDone <= w_done;
            if (w_plot) begin
                oX      <= w_sum_x[7:0];
                oY      <= w_sum_y[6:0];
                oColour <= w_colour;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_character_renderer.sv
// Randomized scoreboard bench for character_renderer (BOX_SIZE 4 and 1 instances).
`timescale 1ns/1ps
`default_nettype none

module tb_character_renderer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    int         cyc = 0;

    logic       start_a = 1'b0, start_b = 1'b0;
    logic [7:0] x_a = '0, x_b = '0;
    logic [6:0] y_a = '0, y_b = '0;
    logic [2:0] c_a = '0, c_b = '0;
    logic [7:0] ox_a, ox_b;
    logic [6:0] oy_a, oy_b;
    logic [2:0] oc_a, oc_b;
    logic       plot_a, plot_b, busy_a, busy_b, done_a, done_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    character_renderer #(.BOX_SIZE(4), .BG_COLOUR(3'b000)) u_dut_a (
        .iClock(clk), .iResetn(rstn), .iStart(start_a), .iX(x_a), .iY(y_a), .iColour(c_a),
        .oX(ox_a), .oY(oy_a), .oColour(oc_a), .oPlot(plot_a), .oBusy(busy_a), .oDone(done_a)
    );

    character_renderer #(.BOX_SIZE(1), .BG_COLOUR(3'b000)) u_dut_b (
        .iClock(clk), .iResetn(rstn), .iStart(start_b), .iX(x_b), .iY(y_b), .iColour(c_b),
        .oX(ox_b), .oY(oy_b), .oColour(oc_b), .oPlot(plot_b), .oBusy(busy_b), .oDone(done_b)
    );

    typedef struct packed {
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t qa[$];
    pix_t qb[$];
    int   dqa[$];
    int   dqb[$];
    int   compared = 0;
    int   mismatched = 0;
    int   done_cnt[2] = '{0, 0};

    // Reference model state: is there a box on screen, and where
    bit   mv[2] = '{0, 0};
    int   mox[2] = '{0, 0};
    int   moy[2] = '{0, 0};

    task automatic check(string name, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_pix(int d, int px, int py, int col);
        pix_t p;
        p.plot = (px <= 159) && (py <= 119);
        p.x    = 8'(px);
        p.y    = 7'(py);
        p.c    = 3'(col);
        if (d == 0) qa.push_back(p);
        else        qb.push_back(p);
    endtask

    // Expected pixel-cycle sequence and completion cycle for one redraw
    task automatic model_redraw(int d, int nx, int ny, int col, int start_cyc);
        int box = (d == 0) ? 4 : 1;
        int n   = 0;
        if (mv[d]) begin
            for (int dy = 0; dy < box; dy++)
                for (int dx = 0; dx < box; dx++) begin
                    push_pix(d, mox[d] + dx, moy[d] + dy, 0);
                    n++;
                end
        end
        for (int dy = 0; dy < box; dy++)
            for (int dx = 0; dx < box; dx++) begin
                push_pix(d, nx + dx, ny + dy, col);
                n++;
            end
        mox[d] = nx;
        moy[d] = ny;
        mv[d]  = 1'b1;
        if (d == 0) dqa.push_back(start_cyc + n + 2);
        else        dqb.push_back(start_cyc + n + 2);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        pix_t p;
        if (rstn) begin
            if (busy_a) begin
                if (qa.size() == 0) check("a_unexpected_busy", 1, 0);
                else begin
                    p = qa.pop_front();
                    check("a_plot", int'(plot_a), int'(p.plot));
                    if (p.plot) begin
                        check("a_x", int'(ox_a), int'(p.x));
                        check("a_y", int'(oy_a), int'(p.y));
                        check("a_colour", int'(oc_a), int'(p.c));
                    end
                end
            end else if (plot_a) begin
                check("a_plot_while_idle", 1, 0);
            end
            if (done_a) begin
                if (dqa.size() == 0) check("a_unexpected_done", 1, 0);
                else begin
                    check("a_done_cycle", cyc, dqa.pop_front());
                    check("a_pixels_left_at_done", qa.size(), 0);
                    check("a_busy_at_done", int'(busy_a), 0);
                end
                done_cnt[0]++;
            end
        end
    end

    always @(negedge clk) begin
        pix_t p;
        if (rstn) begin
            if (busy_b) begin
                if (qb.size() == 0) check("b_unexpected_busy", 1, 0);
                else begin
                    p = qb.pop_front();
                    check("b_plot", int'(plot_b), int'(p.plot));
                    if (p.plot) begin
                        check("b_x", int'(ox_b), int'(p.x));
                        check("b_y", int'(oy_b), int'(p.y));
                        check("b_colour", int'(oc_b), int'(p.c));
                    end
                end
            end else if (plot_b) begin
                check("b_plot_while_idle", 1, 0);
            end
            if (done_b) begin
                if (dqb.size() == 0) check("b_unexpected_done", 1, 0);
                else begin
                    check("b_done_cycle", cyc, dqb.pop_front());
                    check("b_pixels_left_at_done", qb.size(), 0);
                end
                done_cnt[1]++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_start(int d, logic s, int x, int y, int c);
        if (d == 0) begin start_a = s; x_a = 8'(x); y_a = 7'(y); c_a = 3'(c); end
        else        begin start_b = s; x_b = 8'(x); y_b = 7'(y); c_b = 3'(c); end
    endtask

    // mode 0: plain; 1: extra iStart during DRAW; 2: extra iStart in the DONE cycle
    task automatic redraw(int d, int x, int y, int c, int mode);
        int box    = (d == 0) ? 4 : 1;
        int p_cyc  = box * box * (mv[d] ? 2 : 1);
        int target = done_cnt[d] + 1;
        int k      = 0;
        @(negedge clk);
        set_start(d, 1'b1, x, y, c);
        model_redraw(d, x, y, c, cyc);
        @(negedge clk);
        set_start(d, 1'b0, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7));
        if (mode == 1 && p_cyc >= 8) begin
            repeat (p_cyc - 4) @(negedge clk);
            set_start(d, 1'b1, (x + 37) % 160, (y + 11) % 120, c ^ 3'b111);
            @(negedge clk);
            set_start(d, 1'b0, 0, 0, 0);
        end else if (mode == 2) begin
            repeat (p_cyc) @(negedge clk);
            set_start(d, 1'b1, (x + 3) % 160, (y + 5) % 120, c ^ 3'b101);
            @(negedge clk);
            set_start(d, 1'b0, 0, 0, 0);
        end
        while (done_cnt[d] < target && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("redraw_completed", int'(done_cnt[d] >= target), 1);
        if (done_cnt[d] < target) begin
            if (d == 0) begin qa.delete(); dqa.delete(); end
            else        begin qb.delete(); dqb.delete(); end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_a_x"}, int'(ox_a), 0);
        check({tag, "_a_y"}, int'(oy_a), 0);
        check({tag, "_a_colour"}, int'(oc_a), 0);
        check({tag, "_a_plot"}, int'(plot_a), 0);
        check({tag, "_a_busy"}, int'(busy_a), 0);
        check({tag, "_a_done"}, int'(done_a), 0);
        check({tag, "_b_plot"}, int'(plot_b), 0);
        check({tag, "_b_busy"}, int'(busy_b), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #2 rstn = 1'b1;

        redraw(0, 5, 5, 3'b100, 0);
        redraw(0, 6, 5, 3'b100, 0);
        redraw(0, 158, 118, $urandom_range(0, 7), 0);
        redraw(0, 30, 40, 3'b010, 1);
        redraw(0, 30, 40, 3'b101, 2);
        redraw(0, 100, 115, 3'b011, 0);

        redraw(1, 0, 0, 3'b110, 0);
        redraw(1, 1, 0, 3'b110, 0);
        redraw(1, 159, 119, 3'b001, 2);
        redraw(1, 160, 50, 3'b111, 0);

        for (int i = 0; i < 14; i++) begin
            redraw(0, $urandom_range(0, 170), $urandom_range(0, 127),
                   $urandom_range(0, 7), $urandom_range(0, 2));
            if (i % 3 == 0)
                redraw(1, $urandom_range(0, 165), $urandom_range(0, 125),
                       $urandom_range(0, 7), $urandom_range(0, 2) == 2 ? 2 : 0);
        end

        // Abort a redraw at its 7th erase pixel
        redraw(0, 50, 60, 3'b001, 0);
        @(negedge clk);
        set_start(0, 1'b1, 70, 80, 3'b110);
        model_redraw(0, 70, 80, 3'b110, cyc);
        @(negedge clk);
        set_start(0, 1'b0, 0, 0, 0);
        repeat (7) @(negedge clk);
        #2 rstn = 1'b0;
        #1 check_reset_outputs("async_reset");
        qa.delete(); dqa.delete(); qb.delete(); dqb.delete();
        mv[0] = 1'b0;
        mv[1] = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("held_reset");
        @(posedge clk);
        #2 rstn = 1'b1;

        redraw(0, 20, 20, $urandom_range(0, 7), 0);
        redraw(1, 7, 9, 3'b010, 0);
        redraw(0, 21, 22, $urandom_range(0, 7), 0);

        check("a_queue_empty_at_end", qa.size() + dqa.size(), 0);
        check("b_queue_empty_at_end", qb.size() + dqb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/character_renderer.md
CHARACTER_RENDERER -- requirements
Module: character_renderer

Interface
REQ-001 SHALL have parameter BOX_SIZE, default 4, side length in pixels of the square character box (legal 1..8).
REQ-002 SHALL have parameter BG_COLOUR, default 3'b000, colour used to erase the previous box.
REQ-003 SHALL have port iClock, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port iResetn, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port iStart, input, 1, single-cycle request to redraw (driven by the frame enable).
REQ-006 SHALL have port iX, input, 8, new character top-left X (0..159 visible).
REQ-007 SHALL have port iY, input, 7, new character top-left Y (0..119 visible).
REQ-008 SHALL have port iColour, input, 3, character colour.
REQ-009 SHALL have port oX, output, 8, VGA pixel X.
REQ-010 SHALL have port oY, output, 7, VGA pixel Y.
REQ-011 SHALL have port oColour, output, 3, VGA pixel colour.
REQ-012 SHALL have port oPlot, output, 1, pixel write enable for the VGA adapter.
REQ-013 SHALL have port oBusy, output, 1, high while erasing or drawing.
REQ-014 SHALL have port oDone, output, 1, one-cycle pulse when a redraw completes.

Function
REQ-015 SHALL implement states IDLE, ERASE, DRAW, DONE.
REQ-016 In IDLE, iStart=1 SHALL latch iX, iY, iColour into new-position registers and go to ERASE if a previous box is valid, else to DRAW.
REQ-017 iStart SHALL be ignored in ERASE, DRAW and DONE; the latched values SHALL NOT change mid-redraw.
REQ-018 ERASE SHALL emit BOX_SIZE*BOX_SIZE pixels, one per clock, raster order (dx fastest, then dy), at old position + (dx,dy), colour BG_COLOUR.
REQ-019 DRAW SHALL emit BOX_SIZE*BOX_SIZE pixels in the same order at the latched new position, colour latched iColour.
REQ-020 Outputs SHALL be registered: the pixel for counter value (dx,dy) appears on oX/oY/oColour/oPlot the cycle after the counter holds it.
REQ-021 First plotted pixel SHALL appear 2 cycles after the iStart cycle; a full redraw with erase SHALL take 2*BOX_SIZE^2 plot cycles.
REQ-022 Coordinate sums SHALL be computed one bit wider than the port; a pixel with X>159 or Y>119 SHALL drive oPlot=0 for its cycle (clipped, cycle still consumed, no wrap-around).
REQ-023 On leaving DRAW, old-position registers SHALL be loaded with the new position and the previous-box-valid flag set.
REQ-024 DONE SHALL last exactly one cycle with oDone=1, then return to IDLE; iStart in the DONE cycle SHALL be ignored.
REQ-025 oBusy SHALL be 1 in ERASE and DRAW and 0 in IDLE and DONE.
REQ-026 oPlot SHALL be 0 in IDLE and DONE; oX/oY/oColour hold their last values when oPlot=0.
REQ-027 A redraw with unchanged position SHALL still perform erase then draw.

Reset
REQ-028 iResetn=0 SHALL immediately force IDLE, oX=0, oY=0, oColour=0, oPlot=0, oBusy=0, oDone=0, counters 0, previous-box-valid flag 0.
REQ-029 Reset asserted mid-ERASE or mid-DRAW SHALL abort the redraw; the next iStart after release SHALL perform DRAW only (no erase).

Verification
REQ-030 Reset release, iStart with iX=5, iY=5, iColour=3'b100 -> 16 plots, (5,5)..(8,8) raster order, colour 100, no erase, oDone pulse 1 cycle after last plot.
REQ-031 Then iStart with iX=6, iY=5 -> 16 erase plots at (5,5)..(8,8) colour 000, then 16 draw plots at (6,5)..(9,8) colour 100; 32 consecutive plot cycles.
REQ-032 iStart with iX=158, iY=118 -> only (158,118),(159,118),(158,119),(159,119) plotted; other 12 draw cycles oPlot=0; total draw phase still 16 cycles.
REQ-033 iStart pulsed again during DRAW with different iX -> ignored; drawn position and old-position register reflect first request only.
REQ-034 Reset asserted at 7th ERASE pixel -> outputs zero asynchronously; next iStart (iX=20, iY=20) -> draw only, 16 plots at (20,20)..(23,23).
REQ-035 BOX_SIZE=1 instance: iStart at (0,0) then (1,0) -> one erase plot (0,0) colour 000, one draw plot (1,0), oDone after 2 plot cycles.
